// File: rtl/sync_gate_pkg.sv
// sync_gate_pkg: shared state encoding and default sizes for sync_gate_seq
package sync_gate_pkg;
    localparam int DEF_NUM_CH  = 4;
    localparam int DEF_CNT_W   = 8;
    localparam int DEF_BURST_W = 4;
    typedef enum logic [1:0] {IDLE = 2'd0, GATE = 2'd1, GAP = 2'd2, DONE = 2'd3} state_e;
endpackage

// File: rtl/sgc_down_cnt.sv
// sgc_down_cnt: loadable saturating down counter with zero flag
module sgc_down_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);
    logic [W-1:0] cnt_q, cnt_d;
    always_comb cnt_d = load ? load_val : (dec && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
    assign zero = (cnt_q == '0);
endmodule

// File: rtl/sync_gate_seq.sv
// sync_gate_seq: multi-channel burst gate sequencer with gate/gap timing and abort
module sync_gate_seq
    import sync_gate_pkg::*;
#(
    parameter int NUM_CH  = DEF_NUM_CH,
    parameter int CNT_W   = DEF_CNT_W,
    parameter int BURST_W = DEF_BURST_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic [NUM_CH-1:0]  ch_en,
    input  logic [CNT_W-1:0]   gate_len,
    input  logic [CNT_W-1:0]   gap_len,
    input  logic [BURST_W-1:0] burst,
    output logic               sync,
    output logic [NUM_CH-1:0]  gate,
    output logic               done,
    output logic               aborted,
    output logic               busy
);
    state_e               state_q, state_d;
    logic [NUM_CH-1:0]    mask_q, mask_d;
    logic [CNT_W-1:0]     gate_m1_q, gate_m1_d, gap_q, gap_d;
    logic                 aborted_q, aborted_d;
    logic [1:0]           rst_sync_q, rst_sync_d;
    logic                 len_load, len_dec, len_zero, pul_load, pul_dec, pul_zero, accept;
    logic [CNT_W-1:0]     len_val, gate_m1_in;
    logic [BURST_W-1:0]   pul_val;
    // Counters hold "cycles remaining after this one", so length N loads N-1.
    assign gate_m1_in = (gate_len == '0) ? '0 : gate_len - 1'b1;
    assign pul_val    = (burst == '0) ? '0 : burst - 1'b1;
    assign accept     = start && !abort && (ch_en != '0) && rst_sync_q[1];
    always_comb begin
        state_d    = state_q;
        mask_d     = mask_q;
        gate_m1_d  = gate_m1_q;
        gap_d      = gap_q;
        aborted_d  = aborted_q;
        rst_sync_d = {rst_sync_q[0], 1'b1};
        len_load   = 1'b0;
        len_val    = gate_m1_q;
        len_dec    = 1'b0;
        pul_load   = 1'b0;
        pul_dec    = 1'b0;
        case (state_q)
            IDLE: if (accept) begin
                state_d   = GATE;
                mask_d    = ch_en;
                gate_m1_d = gate_m1_in;
                gap_d     = gap_len;
                aborted_d = 1'b0;
                len_load  = 1'b1;
                len_val   = gate_m1_in;
                pul_load  = 1'b1;
            end
            GATE: if (abort) begin
                state_d   = DONE;
                aborted_d = 1'b1;
            end else if (!len_zero) begin
                len_dec = 1'b1;
            end else if (pul_zero) begin
                state_d = DONE;
            end else begin
                pul_dec  = 1'b1;
                len_load = 1'b1;
                state_d  = (gap_q != '0) ? GAP : GATE;
                len_val  = (gap_q != '0) ? gap_q - 1'b1 : gate_m1_q;
            end
            GAP: if (abort) begin
                state_d   = DONE;
                aborted_d = 1'b1;
            end else if (len_zero) begin
                state_d  = GATE;
                len_load = 1'b1;
            end else begin
                len_dec = 1'b1;
            end
            DONE: begin
                state_d   = IDLE;
                aborted_d = 1'b0;
            end
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            mask_q     <= '0;
            gate_m1_q  <= '0;
            gap_q      <= '0;
            aborted_q  <= 1'b0;
            rst_sync_q <= '0;
        end else begin
            state_q    <= state_d;
            mask_q     <= mask_d;
            gate_m1_q  <= gate_m1_d;
            gap_q      <= gap_d;
            aborted_q  <= aborted_d;
            rst_sync_q <= rst_sync_d;
        end
    end
    sgc_down_cnt #(.W(CNT_W)) u_len_cnt (
        .clk(clk), .rst_n(rst_n), .load(len_load), .load_val(len_val), .dec(len_dec), .zero(len_zero)
    );
    sgc_down_cnt #(.W(BURST_W)) u_pul_cnt (
        .clk(clk), .rst_n(rst_n), .load(pul_load), .load_val(pul_val), .dec(pul_dec), .zero(pul_zero)
    );
    assign sync    = (state_q == IDLE);
    assign busy    = !sync;
    assign gate    = (state_q == GATE) ? mask_q : '0;
    assign done    = (state_q == DONE);
    assign aborted = aborted_q;
endmodule

// File: tb/tb_sync_gate_seq.sv
// tb_sync_gate_seq: directed bursts checked against a per-cycle schedule model
module tb_sync_gate_seq;
    logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0;
    logic [3:0] ch_en = '0, burst = '0;
    logic [7:0] gate_len = '0, gap_len = '0;
    logic       sync, done, aborted, busy;
    logic [3:0] gate;
    logic [7:0] obs;
    int         n_chk = 0, n_fail = 0, since_rel = 0;
    typedef struct packed {logic [3:0] g; logic d; logic a;} exp_t;
    exp_t       q[$];
    logic [7:0] exp_basic [10];
    logic [7:0] tr [10];

    sync_gate_seq dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .ch_en(ch_en),
        .gate_len(gate_len), .gap_len(gap_len), .burst(burst),
        .sync(sync), .gate(gate), .done(done), .aborted(aborted), .busy(busy)
    );

    always #5 clk = ~clk;
    assign obs = {sync, busy, done, aborted, gate};

    function automatic exp_t mk(input logic [3:0] g, input logic d, input logic a);
        exp_t e;
        e.g = g; e.d = d; e.a = a;
        return e;
    endfunction

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t got=%b expected=%b", nm, $time, act, exp);
        end
    endtask

    // Expand an accepted request into the exact per-cycle output schedule.
    task automatic build(input logic [3:0] m, input int gl, input int gp, input int b);
        int p = (b == 0) ? 1 : b;
        int g = (gl == 0) ? 1 : gl;
        for (int i = 0; i < p; i++) begin
            for (int j = 0; j < g; j++) q.push_back(mk(m, 1'b0, 1'b0));
            if (i < p - 1) for (int j = 0; j < gp; j++) q.push_back(mk(4'b0, 1'b0, 1'b0));
        end
        q.push_back(mk(4'b0, 1'b1, 1'b0));
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            since_rel = 0;
        end else begin
            since_rel++;
            if (q.size() == 0) begin
                if (start && !abort && ch_en != 0 && since_rel >= 2)
                    build(ch_en, int'(gate_len), int'(gap_len), int'(burst));
            end else if (abort && !q[0].d) begin
                q.delete();
                q.push_back(mk(4'b0, 1'b1, 1'b1));
            end else begin
                void'(q.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        chk("cycle_model", obs, (q.size() == 0) ? 8'b1000_0000 : {2'b01, q[0].d, q[0].a, q[0].g});
    end

    task automatic start_burst(input logic [3:0] m, input logic [7:0] gl, input logic [7:0] gp, input logic [3:0] b);
        @(posedge clk); #1;
        ch_en = m; gate_len = gl; gap_len = gp; burst = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    initial begin
        exp_basic = '{8'h45, 8'h45, 8'h45, 8'h40, 8'h40, 8'h45, 8'h45, 8'h45, 8'h60, 8'h80};
        @(negedge clk);
        chk("reset_state", obs, 8'h80);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        chk("idle_after_reset", obs, 8'h80);
        start_burst(4'b0101, 8'd3, 8'd2, 4'd2);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            tr[i] = obs;
        end
        for (int i = 0; i < 10; i++) chk($sformatf("basic_burst[%0d]", i), tr[i], exp_basic[i]);
        start_burst(4'b1000, 8'd0, 8'd0, 4'd0);
        @(negedge clk) chk("zero_gate", obs, 8'h48);
        @(negedge clk) chk("zero_done", obs, 8'h60);
        @(negedge clk) chk("zero_idle", obs, 8'h80);
        start_burst(4'b1111, 8'd5, 8'd3, 4'd3);
        repeat (6) @(posedge clk);
        #1 abort = 1'b1;
        @(negedge clk) chk("abort_gap2", obs, 8'h40);
        @(posedge clk); #1 abort = 1'b0;
        @(negedge clk) chk("abort_done", obs, 8'h70);
        @(negedge clk) chk("abort_idle", obs, 8'h80);
        @(posedge clk); #1 start = 1'b1; ch_en = 4'b0; gate_len = 8'd3; burst = 4'd1;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk) chk("start_no_mask", obs, 8'h80);
        @(posedge clk); #1 start = 1'b1; abort = 1'b1; ch_en = 4'b1111;
        @(posedge clk); #1 start = 1'b0; abort = 1'b0;
        @(negedge clk) chk("start_abort_idle", obs, 8'h80);
        start_burst(4'b0001, 8'd4, 8'd0, 4'd1);
        @(posedge clk); #1 start = 1'b1; ch_en = 4'b1111; gate_len = 8'd1;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk) chk("start_while_busy", obs, 8'h41);
        repeat (4) @(posedge clk);
        start_burst(4'b0010, 8'd2, 8'd0, 4'd1);
        @(posedge clk); #1 abort = 1'b1;
        @(negedge clk) chk("abort_last_gate", obs, 8'h42);
        @(posedge clk); #1;
        @(negedge clk) chk("abort_last_done", obs, 8'h70);
        repeat (2) @(posedge clk);
        #1 abort = 1'b0;
        start_burst(4'b0011, 8'd2, 8'd0, 4'd3);
        repeat (9) @(posedge clk);
        start_burst(4'b0110, 8'd1, 8'd1, 4'd15);
        repeat (32) @(posedge clk);
        start_burst(4'b1111, 8'hFF, 8'hFF, 4'd2);
        repeat (770) @(posedge clk);
        start_burst(4'b1010, 8'd6, 8'd1, 4'd1);
        @(posedge clk); #3 rst_n = 1'b0;
        #1 chk("async_reset_gate", obs, 8'h80);
        @(posedge clk);
        @(posedge clk); #2;
        rst_n = 1'b1; start = 1'b1; ch_en = 4'b1111; gate_len = 8'd1; burst = 4'd1;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk) chk("start_first_edge_ignored", obs, 8'h80);
        repeat (6) @(posedge clk);
        start_burst(4'b0100, 8'd1, 8'd1, 4'd2);
        @(negedge clk) chk("post_reset_burst", obs, 8'h44);
        repeat (8) @(posedge clk);
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
